minrv32_mem_responder: RTL and testbench

//  Memory-side responder for the minrv32 native memory bus (mem_valid/mem_ready).

---
 rtl/minrv32_mem_responder_if.sv | 24 ++
 rtl/minrv32_mem_responder.sv | 109 ++++++++++
 tb/tb_minrv32_mem_responder.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/minrv32_mem_responder_if.sv
// minrv32 native memory bus plus console byte stream, as seen between a core and its memory.
// The master side issues requests and sinks console bytes; the slave side is the responder.
interface minrv32_mem_responder_if;
  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;

  modport master (
    output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb, tx_ready,
    input  mem_ready, mem_rdata, tx_valid, tx_data
  );

  modport slave (
    input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb, tx_ready,
    output mem_ready, mem_rdata, tx_valid, tx_data
  );
endinterface

// File: rtl/minrv32_mem_responder.sv
// Memory responder for the minrv32 bus: word RAM with programmable wait states, one console
// MMIO word mapped onto a valid/ready byte stream, and a sticky error flag.
module minrv32_mem_responder #(
  parameter int          MEM_WORDS    = 1024,
  parameter int          WAIT_CYCLES  = 1,
  parameter logic [31:0] CONSOLE_ADDR = 32'h1000_0000,
  parameter string       INIT_FILE    = ""
) (
  input  logic                         clk,
  input  logic                         reset,
  minrv32_mem_responder_if.slave       bus,
  output logic                         err
);
  localparam int          AW          = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [29:0] MEM_WORDS_W = 30'(MEM_WORDS);
  localparam logic [3:0]  WAIT_W      = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CONSOLE, S_RESP} state_t;

  state_t      state, state_n;
  logic [3:0]  cnt;
  logic [29:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;

  logic [31:0] ram [0:MEM_WORDS-1];

  logic accept, in_console, q_console, q_in_range, ram_we;
  logic [31:0] ram_word;

  // A pending mem_ready means the core's valid still refers to the answered request.
  assign accept     = (state == S_IDLE) && bus.mem_valid && !bus.mem_ready;
  assign in_console = (bus.mem_addr[31:2] == CONSOLE_ADDR[31:2]);
  assign q_console  = (addr_q == CONSOLE_ADDR[31:2]);
  assign q_in_range = (addr_q < MEM_WORDS_W);
  assign ram_we     = (state == S_RESP) && q_in_range && !q_console && (wstrb_q != 4'd0);
  assign ram_word   = ram[addr_q[AW-1:0]];

  logic unused_bits;
  assign unused_bits = ^{bus.mem_instr, bus.mem_addr[1:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: if (accept) begin
        if (in_console && (bus.mem_wstrb != 4'd0))
          state_n = bus.mem_wstrb[0] ? S_CONSOLE : S_RESP;
        else
          state_n = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
      end
      S_WAIT: begin
        if (!bus.mem_valid)    state_n = S_IDLE;
        else if (cnt == 4'd1)  state_n = S_RESP;
      end
      S_CONSOLE: if (bus.tx_ready) state_n = S_RESP;
      S_RESP:    state_n = S_IDLE;
      default:   state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt           <= 4'd0;
      addr_q        <= 30'd0;
      wdata_q       <= 32'd0;
      wstrb_q       <= 4'd0;
      bus.mem_ready <= 1'b0;
      bus.mem_rdata <= 32'd0;
      bus.tx_valid  <= 1'b0;
      bus.tx_data   <= 8'd0;
      err           <= 1'b0;
    end else begin
      bus.mem_ready <= (state == S_RESP);
      if (accept) begin
        addr_q  <= bus.mem_addr[31:2];
        wdata_q <= bus.mem_wdata;
        wstrb_q <= bus.mem_wstrb;
        cnt     <= WAIT_W;
        if (in_console && bus.mem_wstrb[0]) begin
          bus.tx_valid <= 1'b1;
          bus.tx_data  <= bus.mem_wdata[7:0];
        end
      end
      if (state == S_WAIT) begin
        if (!bus.mem_valid) err <= 1'b1;
        else                cnt <= cnt - 4'd1;
      end
      if (state == S_CONSOLE && bus.tx_ready) bus.tx_valid <= 1'b0;
      // Console and out-of-range accesses read as zero; only the latter is an error.
      if (state == S_RESP) begin
        bus.mem_rdata <= (q_in_range && !q_console) ? ram_word : 32'd0;
        if (!q_in_range && !q_console) err <= 1'b1;
      end
    end
  end

  // RAM contents survive reset; a reset forces IDLE so no write can commit afterwards.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++)
        if (wstrb_q[i]) ram[addr_q[AW-1:0]][8*i +: 8] <= wdata_q[8*i +: 8];
    end
  end
endmodule

// File: tb/tb_minrv32_mem_responder.sv
// Directed bench for minrv32_mem_responder: vector table of RAM accesses plus hand-written
// sequences for reset mid-request, console backpressure, errors and back-to-back requests.
module tb_minrv32_mem_responder;
  localparam int          W     = 3;
  localparam int          WORDS = 1024;
  localparam logic [31:0] CON   = 32'h1000_0000;

  logic clk = 1'b0;
  logic reset;
  logic err;
  minrv32_mem_responder_if bus();

  minrv32_mem_responder #(.MEM_WORDS(WORDS), .WAIT_CYCLES(W), .CONSOLE_ADDR(CON), .INIT_FILE(""))
    dut (.clk(clk), .reset(reset), .bus(bus), .err(err));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic access(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        output logic [31:0] rd, output int lat);
    @(negedge clk);
    bus.mem_valid = 1'b1; bus.mem_addr = a; bus.mem_wdata = d; bus.mem_wstrb = s;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!bus.mem_ready && lat < 50);
    rd = bus.mem_rdata;
    bus.mem_valid = 1'b0; bus.mem_wstrb = 4'd0;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vt[10];
  logic [31:0] rd;
  int lat;
  int bad;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    vt[0] = '{32'h10,  32'hDEADBEEF, 4'hF, 32'h0};
    vt[1] = '{32'h10,  32'h0,        4'h0, 32'hDEADBEEF};
    vt[2] = '{32'h0,   32'h0,        4'hF, 32'h0};
    vt[3] = '{32'h0,   32'hAABBCCDD, 4'h5, 32'h0};
    vt[4] = '{32'h0,   32'h0,        4'h0, 32'h00BB00DD};
    vt[5] = '{32'h4,   32'h11111111, 4'hF, 32'h0};
    vt[6] = '{32'h7,   32'hAABBCCDD, 4'hA, 32'h0};
    vt[7] = '{32'h4,   32'h0,        4'h0, 32'hAA11CC11};
    vt[8] = '{32'hFFC, 32'h12345678, 4'hF, 32'h0};
    vt[9] = '{32'hFFC, 32'h0,        4'h0, 32'h12345678};

    reset = 1'b1;
    bus.mem_valid = 1'b0; bus.mem_instr = 1'b0; bus.mem_addr = 32'd0;
    bus.mem_wdata = 32'd0; bus.mem_wstrb = 4'd0; bus.tx_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'd0, bus.mem_ready}, 32'd0);
    chk("rst_rdata", bus.mem_rdata, 32'd0);
    chk("rst_tx", {23'd0, bus.tx_valid, bus.tx_data}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    reset = 1'b0;

    // Reset during WAIT of a write must drop the request.
    access(32'h40, 32'h55667788, 4'hF, rd, lat);
    access(32'h40, 32'h0, 4'h0, rd, lat);
    chk("pre_rst_rd", rd, 32'h55667788);
    @(negedge clk);
    bus.mem_valid = 1'b1; bus.mem_addr = 32'h40; bus.mem_wdata = 32'h11223344; bus.mem_wstrb = 4'hF;
    bad = 0;
    repeat (2) begin @(negedge clk); if (bus.mem_ready) bad++; end
    reset = 1'b1;
    #1;
    chk("midwait_outs", {bus.mem_ready, bus.tx_valid, bus.tx_data, err}, 32'd0);
    chk("midwait_rdata", bus.mem_rdata, 32'd0);
    @(negedge clk);
    bus.mem_valid = 1'b0; bus.mem_wstrb = 4'd0;
    reset = 1'b0;
    repeat (6) begin @(negedge clk); if (bus.mem_ready) bad++; end
    chk("midwait_noready", bad, 0);
    access(32'h40, 32'h0, 4'h0, rd, lat);
    chk("midwait_word", rd, 32'h55667788);

    for (int i = 0; i < 10; i++) begin
      access(vt[i].addr, vt[i].wdata, vt[i].wstrb, rd, lat);
      chk($sformatf("vec%0d_lat", i), lat, W + 2);
      if (vt[i].wstrb == 4'd0) chk($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rdata);
      @(negedge clk);
      chk($sformatf("vec%0d_pulse", i), {31'd0, bus.mem_ready}, 32'd0);
    end
    chk("no_err_yet", {31'd0, err}, 32'd0);

    // Console read: zero data, normal latency.
    access(CON, 32'h0, 4'h0, rd, lat);
    chk("con_rd_lat", lat, W + 2);
    chk("con_rd_data", rd, 32'd0);

    // Console write under 10 cycles of backpressure.
    @(negedge clk);
    bus.mem_valid = 1'b1; bus.mem_addr = CON; bus.mem_wdata = 32'h41; bus.mem_wstrb = 4'h1;
    @(negedge clk);
    chk("con_tx_up", {23'd0, bus.tx_valid, bus.tx_data}, {23'd0, 1'b1, 8'h41});
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (!bus.tx_valid || bus.tx_data != 8'h41 || bus.mem_ready) bad++;
    end
    chk("con_hold", bad, 0);
    bus.tx_ready = 1'b1;
    @(negedge clk);
    bus.tx_ready = 1'b0;
    chk("con_hs", {30'd0, bus.tx_valid, bus.mem_ready}, 32'd0);
    @(negedge clk);
    chk("con_ready", {31'd0, bus.mem_ready}, 32'd1);
    bus.mem_valid = 1'b0; bus.mem_wstrb = 4'd0;
    @(negedge clk);
    chk("con_done", {30'd0, bus.tx_valid, bus.mem_ready}, 32'd0);

    // Console write without lane 0: no byte, no wait states; stray tx_ready ignored.
    bus.tx_ready = 1'b1;
    access(CON, 32'h4200, 4'h2, rd, lat);
    chk("con_empty_lat", lat, 2);
    chk("con_empty_tx", {31'd0, bus.tx_valid}, 32'd0);
    bus.tx_ready = 1'b0;

    // Out of range: read returns 0, write dropped (would alias word 1), err sticky.
    access(32'h4 * WORDS, 32'h0, 4'h0, rd, lat);
    chk("oor_lat", lat, W + 2);
    chk("oor_rdata", rd, 32'd0);
    chk("oor_err", {31'd0, err}, 32'd1);
    access(32'h4 * WORDS + 32'h4, 32'hFFFFFFFF, 4'hF, rd, lat);
    access(32'h4, 32'h0, 4'h0, rd, lat);
    chk("oor_wr_drop", rd, 32'hAA11CC11);
    chk("err_sticky", {31'd0, err}, 32'd1);

    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst2_outs", {bus.mem_ready, bus.tx_valid, bus.tx_data, err}, 32'd0);

    // Back-to-back fetches with mem_valid held through mem_ready.
    @(negedge clk);
    bus.mem_valid = 1'b1; bus.mem_instr = 1'b1; bus.mem_addr = 32'h0; bus.mem_wstrb = 4'd0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!bus.mem_ready && lat < 50);
    chk("b2b_lat0", lat, W + 2);
    chk("b2b_rd0", bus.mem_rdata, 32'h00BB00DD);
    bus.mem_addr = 32'h4;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!bus.mem_ready && lat < 50);
    chk("b2b_lat1", lat, W + 3);
    chk("b2b_rd1", bus.mem_rdata, 32'hAA11CC11);
    bus.mem_valid = 1'b0; bus.mem_instr = 1'b0;
    bad = 0;
    repeat (8) begin @(negedge clk); if (bus.mem_ready) bad++; end
    chk("b2b_once", bad, 0);
    chk("b2b_err", {31'd0, err}, 32'd0);

    // mem_valid dropped during WAIT.
    @(negedge clk);
    bus.mem_valid = 1'b1; bus.mem_addr = 32'h10; bus.mem_wstrb = 4'd0;
    @(negedge clk);
    bus.mem_valid = 1'b0;
    bad = 0;
    repeat (8) begin @(negedge clk); if (bus.mem_ready) bad++; end
    chk("drop_noready", bad, 0);
    chk("drop_err", {31'd0, err}, 32'd1);
    access(32'h10, 32'h0, 4'h0, rd, lat);
    chk("drop_recover_lat", lat, W + 2);
    chk("drop_recover_rd", rd, 32'hDEADBEEF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
